// File: rtl/video_timing_pattern_gen_if.sv
// Video source bus between the timing/pattern generator and the TMDS encoder.
// The master drives raster timing and pixel data; the slave returns the
// quasi-static pattern select.
interface video_timing_pattern_gen_if;
  logic [1:0] pattern_sel;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    input  pattern_sel,
    output hsync, vsync, de, red, green, blue, frame_start, frame_count
  );

  modport slave (
    output pattern_sel,
    input  hsync, vsync, de, red, green, blue, frame_start, frame_count
  );
endinterface

// File: rtl/video_timing_pattern_gen.sv
// Pixel-clock raster timing generator with a runtime-selectable RGB test pattern.
// Patterns: 0 colour bars, 1 checkerboard, 2 moving grey ramp, 3 flat grey.
// The pattern select is only taken on the frame wrap so a frame never tears.
// Optional build macro TPG_BORDER_EN paints a one-pixel white border around
// the active area on top of whichever pattern is selected.
module video_timing_pattern_gen #(
  parameter int H_ACTIVE    = 1280,
  parameter int H_FP        = 110,
  parameter int H_SYNC      = 40,
  parameter int H_BP        = 220,
  parameter int V_ACTIVE    = 720,
  parameter int V_FP        = 5,
  parameter int V_SYNC      = 5,
  parameter int V_BP        = 20,
  parameter bit HS_POL      = 1'b1,
  parameter bit VS_POL      = 1'b1,
  parameter int CHECK_SHIFT = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  video_timing_pattern_gen_if.master vid
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int BAR_W    = H_ACTIVE / 8;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [HW-1:0] bar_pix_q, bar_pix_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [1:0]    pattern_q, pattern_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          frame_start_q, frame_start_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          frame_wrap;
  logic          active;
  logic          chk_bit;
  logic [7:0]    ramp;

  // Raster counters: h runs across the line, v steps when h wraps, and the
  // double wrap marks the frame boundary where pattern and frame count update.
  always_comb begin
    h_cnt_d       = h_cnt_q + HW'(1);
    v_cnt_d       = v_cnt_q;
    frame_wrap    = 1'b0;
    if (int'(h_cnt_q) == H_TOTAL - 1) begin
      h_cnt_d = '0;
      if (int'(v_cnt_q) == V_TOTAL - 1) begin
        v_cnt_d    = '0;
        frame_wrap = 1'b1;
      end else begin
        v_cnt_d = v_cnt_q + VW'(1);
      end
    end
    pattern_d     = frame_wrap ? vid.pattern_sel : pattern_q;
    frame_count_d = frame_wrap ? frame_count_q + 8'd1 : frame_count_q;
  end

  // Colour-bar tracker: counts pixels within the current bar so the bar index
  // follows h_cnt without a divider; the index sticks at the last (black) bar.
  always_comb begin
    bar_pix_d = bar_pix_q + HW'(1);
    bar_idx_d = bar_idx_q;
    if (h_cnt_d == '0) begin
      bar_pix_d = '0;
      bar_idx_d = '0;
    end else if (int'(bar_pix_q) == BAR_W - 1) begin
      bar_pix_d = '0;
      if (bar_idx_q != 3'd7) begin
        bar_idx_d = bar_idx_q + 3'd1;
      end
    end
  end

  // Output stage: sync, enable and pixel colour for the current counter
  // position, all registered together so they leave the block aligned.
  always_comb begin
    active        = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
    chk_bit       = 1'(((int'(h_cnt_q) >> CHECK_SHIFT) ^ (int'(v_cnt_q) >> CHECK_SHIFT)) & 1);
    ramp          = 8'(h_cnt_q) + frame_count_q;
    de_d          = active;
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    hsync_d       = ((int'(h_cnt_q) >= HS_START) && (int'(h_cnt_q) < HS_END)) ? HS_POL : ~HS_POL;
    vsync_d       = ((int'(v_cnt_q) >= VS_START) && (int'(v_cnt_q) < VS_END)) ? VS_POL : ~VS_POL;
    rgb_d         = 24'h000000;
    if (active) begin
      unique case (pattern_q)
        2'd0: begin
          unique case (bar_idx_q)
            3'd0:    rgb_d = 24'hFFFFFF;
            3'd1:    rgb_d = 24'hFFFF00;
            3'd2:    rgb_d = 24'h00FFFF;
            3'd3:    rgb_d = 24'h00FF00;
            3'd4:    rgb_d = 24'hFF00FF;
            3'd5:    rgb_d = 24'hFF0000;
            3'd6:    rgb_d = 24'h0000FF;
            default: rgb_d = 24'h000000;
          endcase
        end
        2'd1:    rgb_d = chk_bit ? 24'hFFFFFF : 24'h000000;
        2'd2:    rgb_d = {ramp, ramp, ramp};
        default: rgb_d = 24'h808080;
      endcase
`ifdef TPG_BORDER_EN
      if ((h_cnt_q == '0) || (int'(h_cnt_q) == H_ACTIVE - 1) ||
          (v_cnt_q == '0) || (int'(v_cnt_q) == V_ACTIVE - 1)) begin
        rgb_d = 24'hFFFFFF;
      end
`endif
    end
  end

  // State register: reset drops the raster back to pixel (0,0) with blanked,
  // deasserted outputs so the first clock after release shows that pixel.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      bar_pix_q     <= '0;
      bar_idx_q     <= '0;
      pattern_q     <= '0;
      frame_count_q <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      rgb_q         <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      bar_pix_q     <= bar_pix_d;
      bar_idx_q     <= bar_idx_d;
      pattern_q     <= pattern_d;
      frame_count_q <= frame_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
      rgb_q         <= rgb_d;
    end
  end

  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.de          = de_q;
  assign vid.red         = rgb_q[23:16];
  assign vid.green       = rgb_q[15:8];
  assign vid.blue        = rgb_q[7:0];
  assign vid.frame_start = frame_start_q;
  assign vid.frame_count = frame_count_q;

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Directed bench for video_timing_pattern_gen on a small 24x12 raster.
// Expected pixels come from a reference function written from the raster and
// pattern definitions; timing widths/offsets are measured over two frames.
module tb_video_timing_pattern_gen;

  localparam int H_ACTIVE = 16;
  localparam int V_ACTIVE = 8;
  localparam int H_TOTAL  = 24;
  localparam int V_TOTAL  = 12;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  logic clk;
  logic rst_n;

  video_timing_pattern_gen_if vif();

  video_timing_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CHECK_SHIFT(1)
  ) dut (
    .CLK (clk),
    .RST (rst_n),
    .vid (vif)
  );

  int assert_count = 0;
  int fail_count   = 0;
  int edges        = 0;
  int frame_pat    = 0;
  int de_run       = 0;
  int hs_run       = 0;
  int vs_run       = 0;
  int de_total     = 0;
  int fs_total     = 0;
  int last_de_rise = -1000;
  int last_fs      = -1;
  logic prev_de    = 1'b0;
  logic prev_hs    = 1'b0;
  logic prev_vs    = 1'b0;

  // Free-running pixel clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h (edge %0d)", tag, observed, expected, edges);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] sel);
    vif.pattern_sel = sel;
  endtask

  // Reference pixel colour for raster position (x,y), pattern pat, frame f.
  function automatic logic [23:0] expRgb(input int x, input int y, input int pat, input int f);
    logic [7:0] g;
    if (x >= H_ACTIVE || y >= V_ACTIVE) return 24'h000000;
`ifdef TPG_BORDER_EN
    if (x == 0 || x == H_ACTIVE - 1 || y == 0 || y == V_ACTIVE - 1) return 24'hFFFFFF;
`endif
    case (pat)
      0: begin
        case (x / 2)
          0:       return 24'hFFFFFF;
          1:       return 24'hFFFF00;
          2:       return 24'h00FFFF;
          3:       return 24'h00FF00;
          4:       return 24'hFF00FF;
          5:       return 24'hFF0000;
          6:       return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      1: return ((((x / 2) + (y / 2)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
      2: begin
        g = 8'((x + f) % 256);
        return {g, g, g};
      end
      default: return 24'h808080;
    endcase
  endfunction

  // One pixel clock; the DUT latches pattern_sel on every FRAME-th edge.
  task automatic stepCycle();
    @(posedge clk);
    edges++;
    if (edges % FRAME == 0) frame_pat = int'(vif.pattern_sel);
    @(negedge clk);
  endtask

  // Compare every output against the reference for the pixel just emitted.
  task automatic checkPixel();
    int p, q, x, y, f;
    p = edges - 1;
    q = p % FRAME;
    x = q % H_TOTAL;
    y = q / H_TOTAL;
    f = p / FRAME;
    checkOutput("de", 32'(vif.de), 32'((x < H_ACTIVE) && (y < V_ACTIVE)));
    checkOutput("hsync", 32'(vif.hsync), 32'((x >= 18) && (x < 21)));
    checkOutput("vsync", 32'(vif.vsync), 32'((y >= 9) && (y < 11)));
    checkOutput("frame_start", 32'(vif.frame_start), 32'(q == 0));
    checkOutput("rgb", 32'({vif.red, vif.green, vif.blue}), 32'(expRgb(x, y, frame_pat, f)));
    checkOutput("frame_count", 32'(vif.frame_count), 32'(((p + 1) / FRAME) % 256));
  endtask

  // Run-length and offset measurements of the sync/enable waveforms.
  task automatic updateStats();
    if (vif.de && !prev_de) last_de_rise = edges;
    if (!vif.de && prev_de) checkOutput("de_run_length", 32'(de_run), 32'd16);
    de_run = vif.de ? de_run + 1 : 0;
    if (vif.de) de_total++;
    if (vif.hsync && !prev_hs && (edges - last_de_rise) < H_TOTAL)
      checkOutput("hsync_offset", 32'(edges - last_de_rise), 32'd18);
    if (!vif.hsync && prev_hs) checkOutput("hsync_width", 32'(hs_run), 32'd3);
    hs_run = vif.hsync ? hs_run + 1 : 0;
    if (vif.vsync && !prev_vs) checkOutput("vsync_offset", 32'(edges - last_fs), 32'd216);
    if (!vif.vsync && prev_vs) checkOutput("vsync_width", 32'(vs_run), 32'd48);
    vs_run = vif.vsync ? vs_run + 1 : 0;
    if (vif.frame_start) begin
      if (last_fs >= 0) checkOutput("frame_period", 32'(edges - last_fs), 32'(FRAME));
      last_fs = edges;
      fs_total++;
    end
    prev_de = vif.de;
    prev_hs = vif.hsync;
    prev_vs = vif.vsync;
  endtask

  // Directed sequence: reset, six checked frames with pattern changes, async
  // mid-line reset, then a long run to frames 250..256 for the 8-bit wraps.
  initial begin
    rst_n = 1'b1;
    applyStimulus(2'd0);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] checking reset state");
    checkOutput("reset_hsync", 32'(vif.hsync), 32'd0);
    checkOutput("reset_vsync", 32'(vif.vsync), 32'd0);
    checkOutput("reset_de", 32'(vif.de), 32'd0);
    checkOutput("reset_rgb", 32'({vif.red, vif.green, vif.blue}), 32'h0);
    checkOutput("reset_frame_start", 32'(vif.frame_start), 32'd0);
    checkOutput("reset_frame_count", 32'(vif.frame_count), 32'd0);

    #2 rst_n = 1'b1;
    edges = 0;
    frame_pat = 0;
    $display("[TB] frames 0-5: bars, bars->flat at line 4, checker, ramp");
    for (int i = 0; i < 6 * FRAME; i++) begin
      stepCycle();
      checkPixel();
      if (edges <= 2 * FRAME) updateStats();
      if (edges == 1) begin
        checkOutput("first_frame_start", 32'(vif.frame_start), 32'd1);
        checkOutput("first_de", 32'(vif.de), 32'd1);
      end
      if (edges == FRAME + 4 * H_TOTAL) applyStimulus(2'd3);
      if (edges == FRAME + 5 * H_TOTAL + 1)
        checkOutput("midframe_still_bars", 32'({vif.red, vif.green, vif.blue}), 32'(expRgb(0, 5, 0, 1)));
      if (edges == 2 * FRAME) begin
        checkOutput("frame_count_after_two", 32'(vif.frame_count), 32'd2);
        checkOutput("de_total_two_frames", 32'(de_total), 32'd256);
        checkOutput("frame_starts_two_frames", 32'(fs_total), 32'd2);
      end
      if (edges == 2 * FRAME + 1)
        checkOutput("flat_first_pixel", 32'({vif.red, vif.green, vif.blue}), 32'(expRgb(0, 0, 3, 2)));
      if (edges == 2 * FRAME + 100) applyStimulus(2'd1);
      if (edges == 3 * FRAME + 100) applyStimulus(2'd2);
      if (edges == 5 * FRAME + H_TOTAL + 8)
        checkOutput("ramp_fc5_x7", 32'({vif.red, vif.green, vif.blue}), 32'h0C0C0C);
    end

    $display("[TB] asynchronous reset at h=7 v=3");
    while (edges < 6 * FRAME + 3 * H_TOTAL + 7) begin
      stepCycle();
      checkPixel();
    end
    checkOutput("pre_reset_de", 32'(vif.de), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_de", 32'(vif.de), 32'd0);
    checkOutput("async_rgb", 32'({vif.red, vif.green, vif.blue}), 32'h0);
    checkOutput("async_hsync", 32'(vif.hsync), 32'd0);
    checkOutput("async_vsync", 32'(vif.vsync), 32'd0);
    checkOutput("async_frame_start", 32'(vif.frame_start), 32'd0);
    checkOutput("async_frame_count", 32'(vif.frame_count), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    edges = 0;
    frame_pat = 0;
    stepCycle();
    checkOutput("restart_frame_start", 32'(vif.frame_start), 32'd1);
    checkOutput("restart_frame_count", 32'(vif.frame_count), 32'd0);
    checkPixel();
    for (int i = 1; i < FRAME; i++) begin
      stepCycle();
      checkPixel();
    end

    $display("[TB] long run to frames 250..256");
    while (edges < 250 * FRAME) stepCycle();
    for (int i = 0; i < 7 * FRAME; i++) begin
      stepCycle();
      checkPixel();
      if (edges == 250 * FRAME + H_TOTAL + 6)
        checkOutput("ramp_fc250_x5", 32'({vif.red, vif.green, vif.blue}), 32'hFFFFFF);
      if (edges == 250 * FRAME + H_TOTAL + 7)
        checkOutput("ramp_fc250_x6_wrap", 32'({vif.red, vif.green, vif.blue}), 32'h000000);
      if (edges == 255 * FRAME + 1)
        checkOutput("frame_count_255", 32'(vif.frame_count), 32'd255);
      if (edges == 256 * FRAME + 1)
        checkOutput("frame_count_wrap_0", 32'(vif.frame_count), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/video_timing_pattern_gen.md
Name: video_timing_pattern_gen

Overview:
- Pixel-clock-domain source stage. Generates raster timing (hsync, vsync, de) and a selectable RGB test pattern.
- Feeds the DVI/TMDS encoder directly: 8-bit red/green/blue, hsync, vsync, de, all cycle-aligned.
- Replaces the fixed VGA pattern source. Timing comes from parameters; the pattern is selected at runtime and switches only at frame boundaries.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, hsync asserted level
- VS_POL, 1, vsync asserted level
- CHECK_SHIFT, 5, checkerboard square size is 2^CHECK_SHIFT pixels

Ports:
- CLK  input  1  pixel clock
- RST  input  1  asynchronous active-low reset
- pattern_sel  input  2  pattern select; quasi-static; sampled at frame boundary
- hsync  output  1  horizontal sync, polarity HS_POL
- vsync  output  1  vertical sync, polarity VS_POL
- de  output  1  data enable, high during active pixels
- red  output  8  red component
- green  output  8  green component
- blue  output  8  blue component
- frame_start  output  1  one-cycle pulse coincident with output pixel (0,0)
- frame_count  output  8  frames completed since reset, wraps 255->0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- h_cnt runs 0..H_TOTAL-1. It wraps to 0 and increments v_cnt. v_cnt runs 0..V_TOTAL-1 and wraps to 0.
- Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- hsync is asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vsync is asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, across whole lines.
- All outputs are registered with 1-cycle latency from the counters. hsync, vsync, de, RGB and frame_start stay mutually aligned.
- RGB is 0 whenever de=0.
- Reset (RST low, async), effective immediately including mid-frame:
  - counters = 0, pattern register = 0, frame_count = 0
  - de = 0, RGB = 0, frame_start = 0
  - hsync = ~HS_POL, vsync = ~VS_POL
- After RST deassertion, the first output cycle is pixel (0,0): de=1 and frame_start=1.
- Frame wrap: on the clock edge where counters move from (H_TOTAL-1, V_TOTAL-1) to (0,0):
  - pattern_sel is latched into the pattern register.
  - frame_count increments.
  - Pixel (0,0) and all later pixels of that frame use the new values. A pattern_sel change mid-frame has no effect until the next wrap.
- Patterns, with x = h_cnt, y = v_cnt, W = H_ACTIVE/8 (integer):
  - 0 colour bars: 8 bars in order white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
    - Bar index is kept by a within-bar counter, reset at x=0, that advances the index every W pixels.
    - Index saturates at 7, so the remainder pixels are black. No divider.
  - 1 checkerboard: white if x[CHECK_SHIFT]^y[CHECK_SHIFT] is set, else black.
  - 2 moving grey ramp: R=G=B=(x+frame_count) mod 256.
  - 3 flat grey: 808080.
- Width rule: counters are sized by $clog2(H_TOTAL) and $clog2(V_TOTAL). The ramp sum is truncated to 8 bits.

Optional Feature:
- Macro TPG_BORDER_EN.
- When defined: any active pixel with x=0, x=H_ACTIVE-1, y=0 or y=V_ACTIVE-1 is forced to FFFFFF, overriding every pattern. Latency is unchanged.
- When undefined: no border logic; pattern pixels pass through unmodified.

Test Plan:
All scenarios use H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24), V_ACTIVE=8, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=12), CHECK_SHIFT=1.
- Release reset, run 2 frames:
  - de high exactly 16 consecutive cycles per active line, 128 per frame.
  - hsync high 3 cycles starting 18 cycles after de rises.
  - vsync high for exactly 48 cycles, starting 216 cycles after frame_start.
  - frame_start period 288 cycles; frame_count 0->1->2.
- pattern_sel=0: each line shows pixel pairs FFFFFF,FFFFFF,FFFF00,FFFF00,... ending 000000,000000; RGB=0 while de=0.
- pattern_sel=1: line 0 reads 000000,000000,FFFFFF,FFFFFF repeating; line 2 is inverted.
- pattern_sel=2, frame_count=5: line pixels read 05,06,...,14 on all three channels. Same check at frame_count=250 across the 255->0 wrap of the channel value.
- Change pattern_sel 0->3 at line 4 of a frame: remainder of that frame stays colour bars; next frame_start pixel is 808080.
- Assert RST mid-line (h=7, v=3), asynchronously between clock edges:
  - outputs go to reset values without waiting for a clock edge.
  - after release, frame_start=1 on the first cycle and frame_count=0.
- With TPG_BORDER_EN defined and pattern 3: first and last active rows all FFFFFF; x=0 and x=15 are FFFFFF on every active row; interior pixels 808080.
